multi_rate_ticker: RTL and testbench
====================================

Name: multi_rate_ticker

Overview:
- Parametrised successor to the single free-running slow-clock counter.
- Provides NUM_CH independent programmable prescaler channels. Each channel has its own runtime-loadable period, an enable, an exposed count value and a one-cycle Tick pulse.
- Sits beside the game logic and supplies timebases such as physics step, scroll rate and blink rate from the one system clock, so per-rate copies of a hardwired divider are no longer needed.

Parameters:
- WIDTH, 25, bit width of each channel's counter and period register.
- NUM_CH, 4, number of independent channels (1..16).
- CH_W, 2, width of Wr_ch; must satisfy 2**CH_W >= NUM_CH.
- DEFAULT_PERIOD, 25000000, period in clock cycles loaded into every channel at reset; must fit in WIDTH bits.

Ports:
- Clk, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, synchronous active-high reset.
- En, input, 1, global run enable; 0 freezes all channels.
- Ch_en, input, NUM_CH, per-channel run enable; bit i controls channel i.
- Wr_en, input, 1, period write strobe, one cycle.
- Wr_ch, input, CH_W, channel index for the write.
- Wr_period, input, WIDTH, new period in cycles.
- Tick, output, NUM_CH, registered one-cycle pulse per channel at each wrap.
- Count, output, NUM_CH*WIDTH, current counter values; channel i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Single clock domain: Clk. Reset is synchronous, active-high, and has priority over everything else.
- Reset values (registered):
  - every Count slice = 0
  - every period register = DEFAULT_PERIOD
  - Tick = 0
  - toggle outputs (optional feature) = 0
- Effective period Pe = max(P, 1), so P = 0 behaves as P = 1.
- Channel i is active in a cycle when En && Ch_en[i].
- Active channel, C < Pe-1: C <= C+1; Tick[i] <= 0.
- Active channel, C >= Pe-1: C <= 0; Tick[i] <= 1.
  - The >= comparison covers a period lowered below the current count: the channel wraps on the next active cycle and does not run to 2**WIDTH.
- Result: with constant enable, Tick[i] is high for exactly one cycle every Pe cycles, in the same cycle Count slice i reads 0.
  - Pe = 1 gives Tick[i] continuously high and Count held at 0.
- Inactive channel: C holds; Tick[i] <= 0. No tick is lost or queued; counting resumes from the held value.
- Period write (Wr_en = 1 and Wr_ch < NUM_CH):
  - at that edge, P[Wr_ch] <= Wr_period, C[Wr_ch] <= 0, Tick[Wr_ch] <= 0;
  - this applies whether or not the channel is enabled;
  - the first tick after the write comes Pe_new active cycles later.
- Write to the same channel on a cycle where it would wrap: the write wins and no tick is produced.
- Writes to other channels do not disturb a channel.
- Wr_ch >= NUM_CH: the write is ignored and no state changes.
- Counter arithmetic is WIDTH bits unsigned. C never exceeds Pe-1 after the first active cycle following any write or reset.
- Reset asserted mid-count: all channels return to reset values at that edge; there is no Tick on the reset edge.
- Latency:
  - Tick is registered and coincides with the counter wrap edge.
  - A Wr_en edge takes effect at that same edge.
  - The first increment after a write happens on the next active edge.

Optional Feature:
- Macro: MULTI_RATE_TICKER_TOGGLE_EN.
- Defined:
  - adds output port Tog, NUM_CH bits;
  - Tog[i] is registered and inverts on every edge where Tick[i] is set to 1, giving a 50%-duty square wave of period 2*Pe when Pe >= 1;
  - reset sets Tog = 0;
  - a period write to channel i forces Tog[i] to 0;
  - an inactive channel holds Tog[i].
- Undefined: the Tog port and its logic do not exist; all other behaviour is identical.

Test Plan:
- DEFAULT_PERIOD=5, NUM_CH=4. Reset 2 cycles, then En=1, Ch_en=4'b1111 -> every Tick bit pulses high one cycle every 5 cycles; Count slices cycle 1,2,3,4,0; first Tick on the 5th active edge after reset.
- Write Wr_ch=2, Wr_period=3 mid-count (Count2=2) -> Count2=0 at the write edge, no Tick2 that cycle, Tick2 every 3 cycles thereafter; channels 0, 1 and 3 unchanged.
- Lower the period below the current count: channel 1 at Count1=4, write Wr_period=2 -> Count1=0 and Tick1=0 at the write edge. Separately, drop Ch_en[0]=0 for 7 cycles at Count0=3 -> Count0 holds 3 with no Tick0, and resumes to 4 then 0 with Tick on re-enable.
- Wr_period=0 on channel 3 -> Tick3 continuously 1 while enabled, Count3 stays 0. Wr_ch=3 with NUM_CH=3 build -> no state change.
- Assert Reset for one cycle while channels run with mixed periods -> all Count=0, Tick=0, periods back to 5 at that edge. A write and a wrap on the same channel in one cycle -> no Tick, Count=0, new period active.
- With MULTI_RATE_TICKER_TOGGLE_EN and period 5 -> Tog0 high 5 cycles, low 5 cycles. A write to channel 0 forces Tog0=0. Without the macro, the port is absent and the bench builds clean.

Source files
------------

// File: rtl/multi_rate_ticker.sv
// Bank of independent programmable prescaler channels sharing one clock.
// Define MULTI_RATE_TICKER_TOGGLE_EN to add the Tog square-wave outputs.
module multi_rate_ticker #(
    parameter int unsigned WIDTH          = 25,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned DEFAULT_PERIOD = 25000000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    En,
    input  logic [NUM_CH-1:0]       Ch_en,
    input  logic                    Wr_en,
    input  logic [CH_W-1:0]         Wr_ch,
    input  logic [WIDTH-1:0]        Wr_period,
    output logic [NUM_CH-1:0]       Tick,
`ifdef MULTI_RATE_TICKER_TOGGLE_EN
    output logic [NUM_CH-1:0]       Tog,
`endif
    output logic [NUM_CH*WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] One       = WIDTH'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] period_q;
        logic [WIDTH-1:0] count_q;
        logic             tick_q;
        logic [WIDTH-1:0] last;
        logic             wr_hit;
        logic             active;
        logic             wrap;

        // Writes with an out-of-range Wr_ch never match any channel index.
        assign wr_hit = Wr_en && (Wr_ch == CH_W'(i));
        assign active = En && Ch_en[i];
        // Period 0 behaves as period 1, so the last count is 0 either way.
        assign last   = (period_q == '0) ? '0 : period_q - One;
        // >= so that a lowered period wraps immediately instead of overflowing.
        assign wrap   = count_q >= last;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                period_q <= DefPeriod;
                count_q  <= '0;
                tick_q   <= 1'b0;
            end else if (wr_hit) begin
                period_q <= Wr_period;
                count_q  <= '0;
                tick_q   <= 1'b0;
            end else if (active) begin
                if (wrap) begin
                    count_q <= '0;
                    tick_q  <= 1'b1;
                end else begin
                    count_q <= count_q + One;
                    tick_q  <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign Tick[i]                   = tick_q;
        assign Count[i*WIDTH +: WIDTH]   = count_q;

`ifdef MULTI_RATE_TICKER_TOGGLE_EN
        logic tog_q;

        always_ff @(posedge Clk) begin
            if (Reset || wr_hit) begin
                tog_q <= 1'b0;
            end else if (active && wrap) begin
                tog_q <= ~tog_q;
            end
        end

        assign Tog[i] = tog_q;
`endif
    end

endmodule

// File: tb/tb_multi_rate_ticker.sv
// Randomised scoreboard bench for multi_rate_ticker against an integer channel model.
module tb_multi_rate_ticker;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int DP = 5;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           En = 1'b0;
    logic [N-1:0]   Ch_en = '0;
    logic           Wr_en = 1'b0;
    logic [CW-1:0]  Wr_ch = '0;
    logic [W-1:0]   Wr_period = '0;
    logic [N-1:0]   Tick;
    logic [N*W-1:0] Count;
`ifdef MULTI_RATE_TICKER_TOGGLE_EN
    logic [N-1:0]   Tog;
`endif

    multi_rate_ticker #(
        .WIDTH(W),
        .NUM_CH(N),
        .CH_W(CW),
        .DEFAULT_PERIOD(DP)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .En(En),
        .Ch_en(Ch_en),
        .Wr_en(Wr_en),
        .Wr_ch(Wr_ch),
        .Wr_period(Wr_period),
        .Tick(Tick),
`ifdef MULTI_RATE_TICKER_TOGGLE_EN
        .Tog(Tog),
`endif
        .Count(Count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [N-1:0]   tick;
        logic [N*W-1:0] count;
        logic [N-1:0]   tog;
    } exp_t;

    exp_t sb_q[$];

    // Reference state: count, period, tick and toggle per channel as plain ints.
    int mc[N];
    int mp[N];
    int mt[N];
    int mtog[N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic step(input logic rst, input logic en, input logic [N-1:0] chen,
                        input logic wen, input logic [CW-1:0] wch, input logic [W-1:0] wper);
        exp_t e;
        int   pe;
        @(negedge Clk);
        Reset = rst; En = en; Ch_en = chen; Wr_en = wen; Wr_ch = wch; Wr_period = wper;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mc[i] = 0; mp[i] = DP; mt[i] = 0; mtog[i] = 0;
            end else if (wen && int'(wch) == i) begin
                mp[i] = int'(wper); mc[i] = 0; mt[i] = 0; mtog[i] = 0;
            end else if (en && chen[i]) begin
                pe = (mp[i] == 0) ? 1 : mp[i];
                mc[i] = mc[i] + 1;
                if (mc[i] >= pe) begin
                    mc[i] = 0; mt[i] = 1; mtog[i] = 1 - mtog[i];
                end else begin
                    mt[i] = 0;
                end
            end else begin
                mt[i] = 0;
            end
            e.tick[i]          = (mt[i] != 0);
            e.tog[i]           = (mtog[i] != 0);
            e.count[i*W +: W]  = W'(mc[i]);
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [N-1:0] chen);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, chen, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [CW-1:0] ch, input logic [W-1:0] per);
        step(1'b0, 1'b1, 4'b1111, 1'b1, ch, per);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (Tick !== e.tick) begin
                    errors++;
                    $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, Tick, e.tick);
                end
                checks++;
                if (Count !== e.count) begin
                    errors++;
                    $display("FAIL count cyc=%0d got=%h exp=%h", cyc, Count, e.count);
                end
`ifdef MULTI_RATE_TICKER_TOGGLE_EN
                checks++;
                if (Tog !== e.tog) begin
                    errors++;
                    $display("FAIL tog cyc=%0d got=%b exp=%b", cyc, Tog, e.tog);
                end
`endif
                cyc++;
            end
        end
    end

    initial begin : stimulus
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(12, 4'b1111);
        wr(3'd2, 8'd3);          // channel 2 mid-count
        idle(8, 4'b1111);
        wr(3'd1, 8'd2);          // lowered period on channel 1
        idle(5, 4'b1111);
        idle(7, 4'b1110);        // channel 0 frozen
        idle(6, 4'b1111);
        wr(3'd3, 8'd0);          // period 0 behaves as 1
        idle(8, 4'b1111);
        wr(3'd5, 8'd1);          // out-of-range channel ignored
        wr(3'd7, 8'd0);
        idle(3, 4'b1111);
        step(1'b1, 1'b1, 4'b1111, 1'b0, '0, '0);
        idle(4, 4'b1111);
        wr(3'd0, 8'd7);          // write on the wrap cycle of channel 0
        idle(10, 4'b1111);
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                 N'($urandom()), ($urandom_range(0, 7) == 0),
                 CW'($urandom_range(0, 7)), W'($urandom_range(0, 9)));
        end
        step(1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(25, 4'b1111);       // square wave at period 5
        wr(3'd0, 8'd5);
        idle(4, 4'b1111);
        repeat (3) @(posedge Clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
